// File: rtl/seven_segment_scan_rx_pkg.sv
// Shared constants and types for the seven-segment scan receiver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seven_segment_scan_rx_pkg;

    localparam logic [6:0] SEG_0        = 7'b1000000;
    localparam logic [6:0] SEG_1        = 7'b1111001;
    localparam logic [6:0] SEG_2        = 7'b0100100;
    localparam logic [6:0] SEG_2_LEGACY = 7'b1000100;
    localparam logic [6:0] SEG_3        = 7'b0110000;
    localparam logic [6:0] SEG_4        = 7'b0011001;
    localparam logic [6:0] SEG_5        = 7'b0010010;
    localparam logic [6:0] SEG_6        = 7'b0000010;
    localparam logic [6:0] SEG_7        = 7'b1111000;
    localparam logic [6:0] SEG_8        = 7'b0000000;
    localparam logic [6:0] SEG_9        = 7'b0010000;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    // CAPTURE is not a state: it is the COUNT -> HOLD transition.
    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HOLD
    } scan_state_e;

endpackage

// File: rtl/seven_segment_decode.sv
// Combinational decode of an active-low segment pattern back to BCD.
module seven_segment_decode
    import seven_segment_scan_rx_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       err
);

    always_comb begin
        bcd = BCD_INVALID;
        err = 1'b0;
        case (seg)
            SEG_0:        bcd = 4'd0;
            SEG_1:        bcd = 4'd1;
            SEG_2:        bcd = 4'd2;
            SEG_2_LEGACY: bcd = 4'd2;
            SEG_3:        bcd = 4'd3;
            SEG_4:        bcd = 4'd4;
            SEG_5:        bcd = 4'd5;
            SEG_6:        bcd = 4'd6;
            SEG_7:        bcd = 4'd7;
            SEG_8:        bcd = 4'd8;
            SEG_9:        bcd = 4'd9;
            default: begin
                bcd = BCD_INVALID;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_rx.sv
// Receiver for a multiplexed seven-segment bus: waits for each digit to settle,
// decodes it into a per-anode slot and hands complete frames out on valid/ready.
module seven_segment_scan_rx
    import seven_segment_scan_rx_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 8,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] frame_bcd,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    overrun
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [SYNC_STAGES-1:0][6:0]            seg_sync_q;
    logic [SYNC_STAGES-1:0][NUM_DIGITS-1:0] an_sync_q;
    logic [6:0]                             seg_s, seg_prev_q;
    logic [NUM_DIGITS-1:0]                  an_s, an_prev_q, an_sel;
    logic                                   one_hot, pair_same, capture;
    logic [IDX_W-1:0]                       sel_idx;

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0] dec_bcd;
    logic       dec_err;

    logic [NUM_DIGITS-1:0][3:0] slot_bcd_q, slot_bcd_d;
    logic [NUM_DIGITS-1:0]      slot_err_q, slot_err_d;
    logic [NUM_DIGITS-1:0]      seen_q, seen_d;

    logic [4*NUM_DIGITS-1:0] frame_bcd_q, frame_bcd_d;
    logic [NUM_DIGITS-1:0]   frame_err_q, frame_err_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    overrun_q, overrun_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_sync_q <= '0;
            an_sync_q  <= '0;
            seg_prev_q <= '0;
            an_prev_q  <= '0;
        end else begin
            seg_sync_q <= {seg_sync_q[SYNC_STAGES-2:0], seg_n};
            an_sync_q  <= {an_sync_q[SYNC_STAGES-2:0], an_n};
            seg_prev_q <= seg_s;
            an_prev_q  <= an_s;
        end
    end

    assign seg_s     = seg_sync_q[SYNC_STAGES-1];
    assign an_s      = an_sync_q[SYNC_STAGES-1];
    assign an_sel    = ~an_s;
    assign one_hot   = ($countones(an_sel) == 1);
    assign pair_same = (seg_s == seg_prev_q) && (an_s == an_prev_q);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_sel[i]) sel_idx = IDX_W'(i);
        end
    end

    seven_segment_decode u_decode (
        .seg (seg_s),
        .bcd (dec_bcd),
        .err (dec_err)
    );

    // Counter holds the number of consecutive edges the current pair has been seen.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (!one_hot) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = COUNT;
                    cnt_d   = CNT_W'(1);
                end
                COUNT: begin
                    if (!pair_same) begin
                        cnt_d = CNT_W'(1);
                    end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                        cnt_d   = CNT_W'(STABLE_CYCLES);
                        capture = 1'b1;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!pair_same) begin
                        state_d = COUNT;
                        cnt_d   = CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        slot_bcd_d    = slot_bcd_q;
        slot_err_d    = slot_err_q;
        seen_d        = seen_q;
        frame_bcd_d   = frame_bcd_q;
        frame_err_d   = frame_err_q;
        frame_valid_d = frame_valid_q && !frame_ready;
        overrun_d     = overrun_q;
        if (capture) begin
            slot_bcd_d[sel_idx] = dec_bcd;
            slot_err_d[sel_idx] = dec_err;
            seen_d[sel_idx]     = 1'b1;
        end
        // Load uses the next-state slots so a same-edge capture is included.
        if (&seen_q) begin
            seen_d = '0;
            if (!frame_valid_q || frame_ready) begin
                frame_bcd_d   = slot_bcd_d;
                frame_err_d   = slot_err_d;
                frame_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            slot_bcd_q    <= '0;
            slot_err_q    <= '0;
            seen_q        <= '0;
            frame_bcd_q   <= '0;
            frame_err_q   <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            slot_bcd_q    <= slot_bcd_d;
            slot_err_q    <= slot_err_d;
            seen_q        <= seen_d;
            frame_bcd_q   <= frame_bcd_d;
            frame_err_q   <= frame_err_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign frame_bcd   = frame_bcd_q;
    assign frame_err   = frame_err_q;
    assign frame_valid = frame_valid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_seven_segment_scan_rx.sv
// Directed scenarios plus randomized segment streams checked against a
// duration-based model of digit capture and frame assembly.
module tb_seven_segment_scan_rx;
    import seven_segment_scan_rx_pkg::*;

    localparam int NUM_DIGITS    = 4;
    localparam int STABLE_CYCLES = 8;
    localparam int SYNC_STAGES   = 2;

    localparam logic [6:0] PAT_TAB [11] = '{SEG_0, SEG_1, SEG_2, SEG_2_LEGACY, SEG_3, SEG_4,
                                            SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};
    localparam logic [3:0] VAL_TAB [11] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd3, 4'd4,
                                            4'd5, 4'd6, 4'd7, 4'd8, 4'd9};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] frame_bcd;
    logic [3:0]  frame_err;
    logic        frame_valid;
    logic        frame_ready;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    int          accepts = 0;
    logic [15:0] last_bcd = '0;
    logic [3:0]  last_err = '0;
    logic        rand_mode = 1'b0;
    logic [19:0] exp_q [$];

    seven_segment_scan_rx #(
        .NUM_DIGITS    (NUM_DIGITS),
        .STABLE_CYCLES (STABLE_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .frame_bcd   (frame_bcd),
        .frame_err   (frame_err),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < 11; i++) begin
            if (p == PAT_TAB[i]) return {1'b0, VAL_TAB[i]};
        end
        return {1'b1, 4'hF};
    endfunction

    // Records every accepted frame; in random mode compares it with the model queue.
    always begin
        logic [19:0] e;
        @(negedge clk);
        #1;
        if (rst_n && frame_valid && frame_ready) begin
            accepts++;
            last_bcd = frame_bcd;
            last_err = frame_err;
            if (rand_mode) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_frame", {12'd0, frame_err, frame_bcd}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("rand_frame_bcd", {16'd0, frame_bcd}, {16'd0, e[15:0]});
                    check("rand_frame_err", {28'd0, frame_err}, {28'd0, e[19:16]});
                end
            end
        end
    end

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int cycles);
        an_n  = an;
        seg_n = seg;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                        input logic [6:0] p3, input int ndig);
        logic [6:0] pats [4];
        logic [3:0] sel;
        pats = '{p0, p1, p2, p3};
        for (int d = 0; d < ndig; d++) begin
            sel = 4'b0001 << d;
            drive(~sel, pats[d], 16);
        end
    endtask

    task automatic do_reset();
        an_n  = 4'hF;
        seg_n = 7'h7F;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_bcd"}, {16'd0, frame_bcd}, 32'd0);
        check({tag, "_err"}, {28'd0, frame_err}, 32'd0);
        check({tag, "_valid"}, {31'd0, frame_valid}, 32'd0);
        check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        int          base;
        int          first;
        logic [3:0]  an, prev_an, sel;
        logic [6:0]  seg, prev_seg;
        int          hold, k, r;
        logic [3:0]  m_bcd [4];
        logic [3:0]  m_err;
        logic [3:0]  m_seen;
        logic [4:0]  dec;
        logic [15:0] fb;

        rst_n       = 1'b0;
        frame_ready = 1'b1;
        an_n        = 4'hF;
        seg_n       = 7'h7F;
        @(negedge clk);
        do_reset();
        check_outputs_zero("reset");

        // Two full scans of 4,3,2,1 produce two identical frames.
        base = accepts;
        scan(SEG_4, SEG_3, SEG_2, SEG_1, 4);
        scan(SEG_4, SEG_3, SEG_2, SEG_1, 4);
        drive(4'hF, 7'h7F, 20);
        check("scan_frames", accepts - base, 2);
        check("scan_bcd", {16'd0, last_bcd}, 32'h1234);
        check("scan_err", {28'd0, last_err}, 32'd0);
        check("scan_overrun", {31'd0, overrun}, 32'd0);

        // Both encodings of digit 2.
        scan(SEG_0, SEG_1, SEG_2_LEGACY, SEG_3, 4);
        drive(4'hF, 7'h7F, 20);
        check("legacy2_bcd", {16'd0, last_bcd}, 32'h3210);
        check("legacy2_err", {28'd0, last_err}, 32'd0);
        scan(SEG_0, SEG_1, SEG_2, SEG_3, 4);
        drive(4'hF, 7'h7F, 20);
        check("std2_bcd", {16'd0, last_bcd}, 32'h3210);
        check("std2_err", {28'd0, last_err}, 32'd0);

        // Blank pattern is undecodable.
        scan(SEG_8, 7'b1111111, SEG_9, SEG_5, 4);
        drive(4'hF, 7'h7F, 20);
        check("blank_bcd", {16'd0, last_bcd}, 32'h59F8);
        check("blank_err", {28'd0, last_err}, 32'b0010);

        // Toggling faster than the stability window never captures.
        do_reset();
        base = accepts;
        scan(SEG_1, SEG_2, SEG_3, SEG_0, 3);
        for (int i = 0; i < 8; i++) drive(4'b0111, (i % 2 == 0) ? SEG_5 : SEG_6, 5);
        check("toggle_no_frame", accepts - base, 0);
        an_n  = 4'b0111;
        seg_n = SEG_7;
        first = 0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (frame_valid && first == 0) first = j;
        end
        check("capture_latency", first, SYNC_STAGES + STABLE_CYCLES + 1);
        check("latency_bcd", {16'd0, last_bcd}, 32'h7321);
        drive(4'hF, 7'h7F, 5);

        // Back-pressure: second frame dropped, first held.
        do_reset();
        base = accepts;
        frame_ready = 1'b0;
        scan(SEG_4, SEG_3, SEG_2, SEG_1, 4);
        check("bp_valid1", {31'd0, frame_valid}, 32'd1);
        check("bp_bcd1", {16'd0, frame_bcd}, 32'h1234);
        check("bp_overrun1", {31'd0, overrun}, 32'd0);
        scan(SEG_8, SEG_7, SEG_6, SEG_5, 4);
        check("bp_valid2", {31'd0, frame_valid}, 32'd1);
        check("bp_bcd2", {16'd0, frame_bcd}, 32'h1234);
        check("bp_overrun2", {31'd0, overrun}, 32'd1);
        an_n = 4'hF;
        frame_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_drop", {31'd0, frame_valid}, 32'd0);
        check("bp_overrun_sticky", {31'd0, overrun}, 32'd1);
        check("bp_accepts", accepts - base, 1);
        drive(4'hF, 7'h7F, 5);

        // Two anodes low never captures; reset discards partial frame.
        do_reset();
        frame_ready = 1'b0;
        scan(SEG_4, SEG_3, SEG_2, SEG_1, 4);
        scan(SEG_8, SEG_7, SEG_6, SEG_5, 3);
        drive(4'b0101, SEG_9, 20);
        check("twohot_no_overrun", {31'd0, overrun}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("midreset");
        rst_n = 1'b1;
        frame_ready = 1'b1;
        base = accepts;
        drive(4'hF, 7'h7F, 4);
        drive(4'b0111, SEG_5, 16);
        drive(4'hF, 7'h7F, 5);
        check("postreset_partial", accepts - base, 0);
        scan(SEG_0, SEG_9, SEG_8, SEG_5, 3);
        drive(4'hF, 7'h7F, 20);
        check("postreset_frame", accepts - base, 1);
        check("postreset_bcd", {16'd0, last_bcd}, 32'h5890);

        // Randomized segment stream against the duration model.
        do_reset();
        rand_mode = 1'b1;
        m_seen    = '0;
        m_err     = '0;
        for (int i = 0; i < 4; i++) m_bcd[i] = '0;
        prev_an  = 4'hF;
        prev_seg = 7'h7F;
        for (int s = 0; s < 300; s++) begin
            do begin
                r = $urandom_range(0, 99);
                if (r < 70) begin
                    k   = $urandom_range(0, 3);
                    sel = 4'b0001 << k;
                    an  = ~sel;
                end else if (r < 85) begin
                    an = 4'hF;
                end else begin
                    an = 4'($urandom);
                end
                if ($urandom_range(0, 3) != 0) seg = PAT_TAB[$urandom_range(0, 10)];
                else                           seg = 7'($urandom);
            end while (an == prev_an && seg == prev_seg);
            hold = $urandom_range(1, 14);
            if ($countones(~an) == 1 && hold >= STABLE_CYCLES) begin
                for (int i = 0; i < 4; i++) begin
                    if (!an[i]) begin
                        dec      = ref_decode(seg);
                        m_bcd[i] = dec[3:0];
                        m_err[i] = dec[4];
                        m_seen[i] = 1'b1;
                    end
                end
                if (m_seen == 4'hF) begin
                    fb = {m_bcd[3], m_bcd[2], m_bcd[1], m_bcd[0]};
                    exp_q.push_back({m_err, fb});
                    m_seen = '0;
                end
            end
            drive(an, seg, hold);
            prev_an  = an;
            prev_seg = seg;
        end
        if (prev_an != 4'hF || prev_seg != 7'h7F) drive(4'hF, 7'h7F, 30);
        else                                      drive(4'hF, 7'h7E, 30);
        check("rand_pending", exp_q.size(), 0);
        check("rand_overrun", {31'd0, overrun}, 32'd0);
        rand_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
